// File: rtl/mem_pkg.sv
// Shared types and address helpers for the MCU main memory.
`ifndef ADDR_WIDTH
`include "common.sv"
`endif

package mem_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } mem_state_t;

    // Byte address to 16-bit word index; bit 0 is the lane select.
    function automatic logic [`ADDR_WIDTH-2:0] word_index(input logic [`ADDR_WIDTH-1:0] addr);
        return (`ADDR_WIDTH-1)'(addr >> 1);
    endfunction

endpackage

// File: rtl/mcu_mem_if.sv
// MCU memory port bundle: byte address, write strobe/data, read data and clear control.
`ifndef ADDR_WIDTH
`include "common.sv"
`endif

interface mcu_mem_if;
    logic [`ADDR_WIDTH-1:0] mem_addr;
    logic                   wr_mem;
    logic                   byt;
    logic [15:0]            wr_data;
    logic [15:0]            rd_data;
    logic                   clr;
    logic                   busy;

    modport master (
        output mem_addr, wr_mem, byt, wr_data, clr,
        input  rd_data, busy
    );

    modport slave (
        input  mem_addr, wr_mem, byt, wr_data, clr,
        output rd_data, busy
    );
endinterface

// File: rtl/common.sv
// Project-wide address width shared by the MCU and its memory.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif

// File: rtl/mem_bram_be.sv
// Synchronous read-first 16-bit RAM with independent low/high byte write enables.
module mem_bram_be #(
    parameter int WORDS = 1024,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic [AW-1:0] addr_i,
    input  logic [1:0]    we_i,
    input  logic [15:0]   wdata_i,
    output logic [15:0]   rdata_o
);

    logic [15:0] mem_q [WORDS];

    always_ff @(posedge clk) begin
        rdata_o <= mem_q[addr_i];
        if (we_i[0]) mem_q[addr_i][7:0]  <= wdata_i[7:0];
        if (we_i[1]) mem_q[addr_i][15:8] <= wdata_i[15:8];
    end

endmodule

// File: rtl/mcu_mem.sv
// MCU main memory: address decode, byte-lane mux and a clear sequencer that
// owns the RAM port while it sweeps INIT_VALUE across every word.
`ifndef ADDR_WIDTH
`include "common.sv"
`endif

module mcu_mem
    import mem_pkg::*;
#(
    parameter int          MEM_WORDS      = 1024,
    parameter bit          CLEAR_ON_RESET = 1'b1,
    parameter logic [15:0] INIT_VALUE     = 16'h0000
) (
    input  logic      clk,
    input  logic      rst,
    mcu_mem_if.slave  bus
);

    localparam int MEM_IDX_W = $clog2(MEM_WORDS);

    mem_state_t             state_q, state_d;
    logic [MEM_IDX_W-1:0]   cnt_q, cnt_d;
    logic [`ADDR_WIDTH-2:0] idx;
    logic                   in_range, lane;
    logic [MEM_IDX_W-1:0]   ram_addr;
    logic [1:0]             ram_we;
    logic [15:0]            ram_wdata, ram_rdata;
    logic                   rd_vld_q, rd_byt_q, rd_lane_q;

    assign idx      = word_index(bus.mem_addr);
    assign in_range = 32'(idx) < MEM_WORDS;
    assign lane     = bus.mem_addr[0];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ram_addr  = idx[MEM_IDX_W-1:0];
        ram_we    = 2'b00;
        ram_wdata = bus.wr_data;
        case (state_q)
            IDLE: begin
                // clr wins over a same-cycle write; that write is lost.
                if (bus.clr) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end else if (bus.wr_mem && in_range) begin
                    if (bus.byt) begin
                        ram_we    = lane ? 2'b10 : 2'b01;
                        ram_wdata = {2{bus.wr_data[7:0]}};
                    end else begin
                        ram_we = 2'b11;
                    end
                end
            end
            CLEAR: begin
                ram_addr  = cnt_q;
                ram_we    = 2'b11;
                ram_wdata = INIT_VALUE;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == MEM_IDX_W'(MEM_WORDS - 1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR_ON_RESET ? CLEAR : IDLE;
            cnt_q     <= '0;
            rd_vld_q  <= 1'b0;
            rd_byt_q  <= 1'b0;
            rd_lane_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_vld_q  <= (state_q == IDLE) && in_range;
            rd_byt_q  <= bus.byt;
            rd_lane_q <= lane;
        end
    end

    mem_bram_be #(.WORDS(MEM_WORDS), .AW(MEM_IDX_W)) u_ram (
        .clk     (clk),
        .addr_i  (ram_addr),
        .we_i    (ram_we),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    // Out-of-range, reset and clearing all read as zero.
    always_comb begin
        bus.rd_data = 16'h0000;
        if (state_q == IDLE && rd_vld_q)
            bus.rd_data = rd_byt_q ? {8'h00, (rd_lane_q ? ram_rdata[15:8] : ram_rdata[7:0])}
                                   : ram_rdata;
    end

    assign bus.busy = (state_q == CLEAR);

endmodule

// File: tb/tb_mcu_mem.sv
// Directed bench for mcu_mem: a 1024-word instance for data paths and a
// 16-word instance for clear timing, range and reset-abort behaviour.
`ifndef ADDR_WIDTH
`include "common.sv"
`endif

module tb_mcu_mem;

    logic clk = 1'b0;
    logic rst_b, rst_s;
    int   checks = 0;
    int   errors = 0;

    mcu_mem_if big_if();
    mcu_mem_if sml_if();

    mcu_mem #(.MEM_WORDS(1024), .CLEAR_ON_RESET(1'b1), .INIT_VALUE(16'h0000)) u_big (
        .clk (clk), .rst (rst_b), .bus (big_if.slave)
    );

    mcu_mem #(.MEM_WORDS(16), .CLEAR_ON_RESET(1'b1), .INIT_VALUE(16'h0000)) u_sml (
        .clk (clk), .rst (rst_s), .bus (sml_if.slave)
    );

    always #5 clk = ~clk;

    // Present one cycle of inputs; returns at the next negedge, where rd_data
    // reflects this address.
    task automatic b_drive(input logic [15:0] a, input logic w, input logic b, input logic [15:0] d);
        big_if.mem_addr = a; big_if.wr_mem = w; big_if.byt = b; big_if.wr_data = d;
        @(negedge clk);
        big_if.wr_mem = 1'b0;
    endtask

    task automatic s_drive(input logic [15:0] a, input logic w, input logic b, input logic [15:0] d);
        sml_if.mem_addr = a; sml_if.wr_mem = w; sml_if.byt = b; sml_if.wr_data = d;
        @(negedge clk);
        sml_if.wr_mem = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        rst_b = 1'b1; rst_s = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (sml_if.busy !== 1'b1) begin errors++; $display("FAIL reset_busy_s: got %b want 1", sml_if.busy); end
        checks++; if (sml_if.rd_data !== 16'h0000) begin errors++; $display("FAIL reset_rd_s: got %h want 0000", sml_if.rd_data); end
        checks++; if (big_if.busy !== 1'b1) begin errors++; $display("FAIL reset_busy_b: got %b want 1", big_if.busy); end
        rst_b = 1'b0; rst_s = 1'b0;
        n = 1;
        while (n < 100) begin
            @(negedge clk);
            if (sml_if.busy === 1'b1) n++; else break;
        end
        checks++; if (n != 16) begin errors++; $display("FAIL reset_clear_len: got %0d want 16", n); end
        for (int i = 0; i < 16; i++) begin
            s_drive(16'(i * 2), 1'b0, 1'b0, 16'h0);
            checks++;
            if (sml_if.rd_data !== 16'h0000) begin errors++; $display("FAIL reset_zero[%0d]: got %h want 0000", i, sml_if.rd_data); end
        end
        n = 0;
        while (big_if.busy === 1'b1 && n < 2000) begin @(negedge clk); n++; end
        checks++; if (big_if.busy !== 1'b0) begin errors++; $display("FAIL reset_big_done: got %b want 0", big_if.busy); end
    endtask

    task automatic test_word_rw();
        b_drive(16'h0310, 1'b1, 1'b0, 16'hA55A);
        b_drive(16'h0310, 1'b0, 1'b0, 16'h0);
        checks++; if (big_if.rd_data !== 16'hA55A) begin errors++; $display("FAIL word_rd: got %h want a55a", big_if.rd_data); end
        b_drive(16'h0310, 1'b0, 1'b1, 16'h0);
        checks++; if (big_if.rd_data !== 16'h005A) begin errors++; $display("FAIL byte_rd_lo: got %h want 005a", big_if.rd_data); end
        b_drive(16'h0311, 1'b0, 1'b1, 16'h0);
        checks++; if (big_if.rd_data !== 16'h00A5) begin errors++; $display("FAIL byte_rd_hi: got %h want 00a5", big_if.rd_data); end
    endtask

    task automatic test_byte_merge();
        b_drive(16'h0320, 1'b1, 1'b0, 16'h1234);
        b_drive(16'h0321, 1'b1, 1'b1, 16'hFFCD);
        b_drive(16'h0320, 1'b0, 1'b0, 16'h0);
        checks++; if (big_if.rd_data !== 16'hCD34) begin errors++; $display("FAIL merge_hi: got %h want cd34", big_if.rd_data); end
        b_drive(16'h0320, 1'b1, 1'b1, 16'h7799);
        b_drive(16'h0321, 1'b0, 1'b0, 16'h0);
        checks++; if (big_if.rd_data !== 16'hCD99) begin errors++; $display("FAIL merge_lo: got %h want cd99", big_if.rd_data); end
    endtask

    task automatic test_read_first();
        b_drive(16'h0330, 1'b1, 1'b0, 16'hBEEF);
        checks++; if (big_if.rd_data !== 16'h0000) begin errors++; $display("FAIL read_first_old: got %h want 0000", big_if.rd_data); end
        b_drive(16'h0330, 1'b0, 1'b0, 16'h0);
        checks++; if (big_if.rd_data !== 16'hBEEF) begin errors++; $display("FAIL read_first_new: got %h want beef", big_if.rd_data); end
    endtask

    task automatic test_clear();
        int n;
        big_if.clr = 1'b1;
        b_drive(16'h0340, 1'b1, 1'b0, 16'h7777);
        big_if.clr = 1'b0;
        checks++; if (big_if.busy !== 1'b1) begin errors++; $display("FAIL clr_busy_rise: got %b want 1", big_if.busy); end
        n = 1;
        while (n < 2000) begin
            big_if.clr = (n == 500);
            if (n == 10) b_drive(16'h0000, 1'b1, 1'b0, 16'h1234);
            else         b_drive(16'h0310, 1'b0, 1'b0, 16'h0);
            big_if.clr = 1'b0;
            if (n == 5) begin
                checks++;
                if (big_if.rd_data !== 16'h0000) begin errors++; $display("FAIL clr_rd_forced: got %h want 0000", big_if.rd_data); end
            end
            if (big_if.busy === 1'b1) n++; else break;
        end
        checks++; if (n != 1024) begin errors++; $display("FAIL clr_len: got %0d want 1024", n); end
        b_drive(16'h0340, 1'b0, 1'b0, 16'h0);
        checks++; if (big_if.rd_data !== 16'h0000) begin errors++; $display("FAIL clr_drop_wr: got %h want 0000", big_if.rd_data); end
        b_drive(16'h0000, 1'b0, 1'b0, 16'h0);
        checks++; if (big_if.rd_data !== 16'h0000) begin errors++; $display("FAIL clr_ign_wr: got %h want 0000", big_if.rd_data); end
        b_drive(16'h0310, 1'b0, 1'b0, 16'h0);
        checks++; if (big_if.rd_data !== 16'h0000) begin errors++; $display("FAIL clr_wiped: got %h want 0000", big_if.rd_data); end
    endtask

    task automatic test_range_rst();
        int n;
        s_drive(16'h0000, 1'b1, 1'b0, 16'h2222);
        s_drive(16'h0040, 1'b1, 1'b0, 16'h1111);
        s_drive(16'h0040, 1'b0, 1'b0, 16'h0);
        checks++; if (sml_if.rd_data !== 16'h0000) begin errors++; $display("FAIL oor_rd: got %h want 0000", sml_if.rd_data); end
        s_drive(16'h0000, 1'b0, 1'b0, 16'h0);
        checks++; if (sml_if.rd_data !== 16'h2222) begin errors++; $display("FAIL oor_no_wrap: got %h want 2222", sml_if.rd_data); end
        s_drive(16'h001E, 1'b1, 1'b0, 16'h3333);
        s_drive(16'h001F, 1'b0, 1'b1, 16'h0);
        checks++; if (sml_if.rd_data !== 16'h0033) begin errors++; $display("FAIL last_word: got %h want 0033", sml_if.rd_data); end
        sml_if.clr = 1'b1;
        s_drive(16'h0002, 1'b0, 1'b0, 16'h0);
        sml_if.clr = 1'b0;
        repeat (5) s_drive(16'h0002, 1'b0, 1'b0, 16'h0);
        checks++; if (sml_if.busy !== 1'b1) begin errors++; $display("FAIL mid_clr_busy: got %b want 1", sml_if.busy); end
        rst_s = 1'b1;
        @(negedge clk);
        checks++; if (sml_if.busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy: got %b want 1", sml_if.busy); end
        rst_s = 1'b0;
        n = 1;
        while (n < 100) begin
            @(negedge clk);
            if (sml_if.busy === 1'b1) n++; else break;
        end
        checks++; if (n != 16) begin errors++; $display("FAIL rst_restart_len: got %0d want 16", n); end
        s_drive(16'h0000, 1'b0, 1'b0, 16'h0);
        checks++; if (sml_if.rd_data !== 16'h0000) begin errors++; $display("FAIL rst_wiped0: got %h want 0000", sml_if.rd_data); end
        s_drive(16'h001E, 1'b0, 1'b0, 16'h0);
        checks++; if (sml_if.rd_data !== 16'h0000) begin errors++; $display("FAIL rst_wiped15: got %h want 0000", sml_if.rd_data); end
    endtask

    initial begin
        rst_b = 1'b1; rst_s = 1'b1;
        big_if.mem_addr = '0; big_if.wr_mem = 1'b0; big_if.byt = 1'b0; big_if.wr_data = '0; big_if.clr = 1'b0;
        sml_if.mem_addr = '0; sml_if.wr_mem = 1'b0; sml_if.byt = 1'b0; sml_if.wr_data = '0; sml_if.clr = 1'b0;
        test_reset();
        test_word_rw();
        test_byte_merge();
        test_read_first();
        test_clear();
        test_range_rst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
